// File: rtl/pr_pkg.sv
// Shared widths, Q32.32 constants and FSM state encoding for the PageRank accumulator.
package pr_pkg;

  localparam int unsigned INT_W  = 64;
  localparam int unsigned FRAC_W = 32;

  localparam logic [63:0] DAMP_Q = 64'h0000_0000_D999_999A;
  localparam logic [63:0] ONE_Q  = 64'h0000_0001_0000_0000;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_VERT = 3'd1,
    ACCUM     = 3'd2,
    SCALE     = 3'd3,
    EMIT      = 3'd4
  } state_e;

endpackage

// File: rtl/pr_fxmul.sv
// Combinational unsigned fixed-point multiply: returns the Q-format middle slice of
// the full product plus a flag for nonzero bits above it.
module pr_fxmul
  import pr_pkg::*;
#(
  parameter int unsigned DATA_W    = INT_W,
  parameter int unsigned FRAC_BITS = FRAC_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] prod_c,
  output logic              ovf_c
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic [PROD_W-1:0] full;
  logic              unused_lo;

  assign full      = PROD_W'(a) * PROD_W'(b);
  assign prod_c    = full[FRAC_BITS +: DATA_W];
  assign ovf_c     = |full[PROD_W-1 : FRAC_BITS + DATA_W];
  // Fraction bits below the result are dropped by design.
  assign unused_lo = ^full[FRAC_BITS-1:0];

endmodule

// File: rtl/pr_accum.sv
// PageRank per-vertex accumulator: sums in-edge contributions, applies damping and
// base term, and streams new ranks. Define PR_ACCUM_SAT_EN for saturating arithmetic.
module pr_accum #(
  parameter int unsigned          INT_W  = pr_pkg::INT_W,
  parameter int unsigned          FRAC_W = pr_pkg::FRAC_W,
  parameter logic [INT_W-1:0]     DAMP_Q = INT_W'(pr_pkg::DAMP_Q)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [INT_W-1:0] n_vertices,
  input  logic [INT_W-1:0] base_term,
  input  logic             vert_valid,
  output logic             vert_ready,
  input  logic [INT_W-1:0] vert_deg,
  input  logic             edge_valid,
  output logic             edge_ready,
  input  logic [INT_W-1:0] edge_contrib,
  output logic             rank_valid,
  input  logic             rank_ready,
  output logic [INT_W-1:0] rank_vid,
  output logic [INT_W-1:0] rank_data,
  output logic             done
);

  pr_pkg::state_e   state_q, state_nxt;
  logic [INT_W-1:0] n_q, n_nxt;
  logic [INT_W-1:0] base_q, base_nxt;
  logic [INT_W-1:0] remaining_q, remaining_nxt;
  logic [INT_W-1:0] sum_q, sum_nxt;
  logic [INT_W-1:0] vid_nxt, rank_data_nxt;
  logic             done_nxt, vert_ready_nxt, edge_ready_nxt, rank_valid_nxt;

  logic [INT_W-1:0] mul_prod_c;
  logic             mul_ovf_c;
  logic [INT_W:0]   acc_full, rank_full;
  logic [INT_W-1:0] acc_sum, prod_adj, rank_sum;

  pr_fxmul #(
    .DATA_W   (INT_W),
    .FRAC_BITS(FRAC_W)
  ) u_fxmul (
    .a     (sum_q),
    .b     (DAMP_Q),
    .prod_c(mul_prod_c),
    .ovf_c (mul_ovf_c)
  );

  assign acc_full  = {1'b0, sum_q} + {1'b0, edge_contrib};
  assign rank_full = {1'b0, base_q} + {1'b0, prod_adj};

`ifdef PR_ACCUM_SAT_EN
  assign acc_sum  = acc_full[INT_W]  ? '1 : acc_full[INT_W-1:0];
  assign prod_adj = mul_ovf_c        ? '1 : mul_prod_c;
  assign rank_sum = rank_full[INT_W] ? '1 : rank_full[INT_W-1:0];
`else
  logic unused_carry;
  assign acc_sum      = acc_full[INT_W-1:0];
  assign prod_adj     = mul_prod_c;
  assign rank_sum     = rank_full[INT_W-1:0];
  // Wrapping build drops carries and the high product bits.
  assign unused_carry = ^{acc_full[INT_W], rank_full[INT_W], mul_ovf_c};
`endif

  // Next-state and next-register computation.
  always_comb begin
    state_nxt     = state_q;
    n_nxt         = n_q;
    base_nxt      = base_q;
    remaining_nxt = remaining_q;
    sum_nxt       = sum_q;
    vid_nxt       = rank_vid;
    rank_data_nxt = rank_data;
    done_nxt      = done;

    case (state_q)
      pr_pkg::IDLE: begin
        if (start) begin
          n_nxt    = n_vertices;
          base_nxt = base_term;
          vid_nxt  = '0;
          if (n_vertices == '0) begin
            done_nxt = 1'b1;
          end else begin
            done_nxt  = 1'b0;
            state_nxt = pr_pkg::LOAD_VERT;
          end
        end
      end
      pr_pkg::LOAD_VERT: begin
        if (vert_valid && vert_ready) begin
          remaining_nxt = vert_deg;
          sum_nxt       = '0;
          state_nxt     = (vert_deg != '0) ? pr_pkg::ACCUM : pr_pkg::SCALE;
        end
      end
      pr_pkg::ACCUM: begin
        if (edge_valid && edge_ready) begin
          sum_nxt       = acc_sum;
          remaining_nxt = remaining_q - INT_W'(1);
          if (remaining_q == INT_W'(1)) state_nxt = pr_pkg::SCALE;
        end
      end
      pr_pkg::SCALE: begin
        rank_data_nxt = rank_sum;
        state_nxt     = pr_pkg::EMIT;
      end
      pr_pkg::EMIT: begin
        if (rank_valid && rank_ready) begin
          if (rank_vid == n_q - INT_W'(1)) begin
            done_nxt  = 1'b1;
            state_nxt = pr_pkg::IDLE;
          end else begin
            vid_nxt   = rank_vid + INT_W'(1);
            state_nxt = pr_pkg::LOAD_VERT;
          end
        end
      end
      default: state_nxt = pr_pkg::IDLE;
    endcase

    // Handshake flags are registered decodes of the upcoming state.
    vert_ready_nxt = (state_nxt == pr_pkg::LOAD_VERT);
    edge_ready_nxt = (state_nxt == pr_pkg::ACCUM);
    rank_valid_nxt = (state_nxt == pr_pkg::EMIT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= pr_pkg::IDLE;
      n_q         <= '0;
      base_q      <= '0;
      remaining_q <= '0;
      sum_q       <= '0;
      rank_vid    <= '0;
      rank_data   <= '0;
      done        <= 1'b0;
      vert_ready  <= 1'b0;
      edge_ready  <= 1'b0;
      rank_valid  <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      n_q         <= n_nxt;
      base_q      <= base_nxt;
      remaining_q <= remaining_nxt;
      sum_q       <= sum_nxt;
      rank_vid    <= vid_nxt;
      rank_data   <= rank_data_nxt;
      done        <= done_nxt;
      vert_ready  <= vert_ready_nxt;
      edge_ready  <= edge_ready_nxt;
      rank_valid  <= rank_valid_nxt;
    end
  end

endmodule
